// File: rtl/mlp_output_layer.sv
// mlp_output_layer: requantizes the hidden-layer accumulators, then runs a
// sequential single-MAC dot product per output neuron against a locally
// stored weight/bias file, and reports the raw scores plus the argmax class.
module mlp_output_layer #(
  parameter int HIDDEN_SIZE = 2,
  parameter int ACC_W       = 16,
  parameter int DATA_W      = 8,
  parameter int OUT_DIM     = 2,
  parameter int OUT_ACC_W   = 24,
  parameter int SHIFT       = 4,
  localparam int NW = OUT_DIM * (HIDDEN_SIZE + 1),
  localparam int AW = (NW > 1) ? $clog2(NW) : 1,
  localparam int NB = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ACC_W*HIDDEN_SIZE-1:0]   hidden_in_flat,
  input  logic                           hidden_valid,
  output logic                           hidden_ready,
  input  logic                           w_we,
  input  logic [AW-1:0]                  w_addr,
  input  logic [DATA_W-1:0]              w_data,
  output logic                           busy,
  output logic [OUT_ACC_W*OUT_DIM-1:0]   out_flat,
  output logic [NB-1:0]                  out_argmax,
  output logic                           out_valid
);

  localparam int KB = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
  localparam logic [ACC_W-1:0] QMAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUANT,
    S_MAC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Weight/bias file: neuron n occupies HIDDEN_SIZE weights followed by its bias.
  logic signed [DATA_W-1:0]    w_q     [NW];
  logic [ACC_W*HIDDEN_SIZE-1:0] h_q;
  logic signed [DATA_W-1:0]    q_q     [HIDDEN_SIZE];
  logic signed [OUT_ACC_W-1:0] score_q [OUT_DIM];
  logic signed [OUT_ACC_W-1:0] acc_q;
  logic signed [OUT_ACC_W-1:0] best_q;
  logic [NB-1:0]               best_idx_q;
  logic [NB-1:0]               n_q;
  logic [KB-1:0]               k_q;
  logic [OUT_ACC_W*OUT_DIM-1:0] out_flat_q;
  logic [NB-1:0]               out_argmax_q;
  logic                        out_valid_q;

  logic [AW-1:0]               w_idx;
  logic [NB-1:0]               bias_n;
  logic [AW-1:0]               bias_idx;
  logic signed [DATA_W-1:0]    q_cur;
  logic signed [DATA_W-1:0]    w_cur;
  logic signed [2*DATA_W-1:0]  prod;
  logic signed [OUT_ACC_W-1:0] acc_sum;
  logic signed [OUT_ACC_W-1:0] bias_ext;
  logic                        last_k;
  logic                        last_n;
  logic                        new_best;
  logic                        w_accept;

  // ReLU, arithmetic shift, then saturate to the largest positive DATA_W value.
  function automatic logic signed [DATA_W-1:0] requant(input logic [ACC_W-1:0] h);
    logic [ACC_W-1:0] sh;
    sh = ACC_W'($signed(h) >>> SHIFT);
    if (h[ACC_W-1]) begin
      return '0;
    end else if (sh > QMAX) begin
      return QMAX[DATA_W-1:0];
    end else begin
      return sh[DATA_W-1:0];
    end
  endfunction

  // Next-state logic of the control FSM.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hidden_valid) state_d = S_QUANT;
      S_QUANT: state_d = S_MAC;
      S_MAC:   if (last_k && last_n) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC datapath: current product, running sum, and the bias of the next neuron.
  always_comb begin
    w_idx    = AW'(n_q) * AW'(HIDDEN_SIZE + 1) + AW'(k_q);
    bias_n   = (state_q == S_QUANT) ? '0 : n_q + NB'(1);
    bias_idx = AW'(bias_n) * AW'(HIDDEN_SIZE + 1) + AW'(HIDDEN_SIZE);
    q_cur    = q_q[k_q];
    w_cur    = w_q[w_idx];
    prod     = q_cur * w_cur;
    acc_sum  = acc_q + {{(OUT_ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = {{(OUT_ACC_W - DATA_W){w_q[bias_idx][DATA_W-1]}}, w_q[bias_idx]};
    last_k   = (k_q == KB'(HIDDEN_SIZE - 1));
    last_n   = (n_q == NB'(OUT_DIM - 1));
    new_best = (n_q == '0) || (acc_sum > best_q);
    w_accept = w_we && (state_q == S_IDLE) && (int'(w_addr) < NW);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Weight file writes; only taken while idle so weights are constant during a computation.
  always_ff @(posedge clk) begin
    // NOTE: the weight file is reset explicitly; a reset run must see all-zero weights.
    if (rst) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (w_accept) begin
      w_q[w_addr] <= w_data;
    end
  end

  // Capture, requantize, accumulate, track the best score, and publish results.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q          <= '0;
      for (int i = 0; i < HIDDEN_SIZE; i++) q_q[i] <= '0;
      for (int n = 0; n < OUT_DIM; n++)     score_q[n] <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      n_q          <= '0;
      k_q          <= '0;
      out_flat_q   <= '0;
      out_argmax_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hidden_valid) h_q <= hidden_in_flat;
        end
        S_QUANT: begin
          for (int i = 0; i < HIDDEN_SIZE; i++) begin
            q_q[i] <= requant(h_q[i*ACC_W +: ACC_W]);
          end
          n_q   <= '0;
          k_q   <= '0;
          acc_q <= bias_ext;
        end
        S_MAC: begin
          if (last_k) begin
            score_q[n_q] <= acc_sum;
            if (new_best) begin
              best_q     <= acc_sum;
              best_idx_q <= n_q;
            end
            if (!last_n) begin
              n_q   <= n_q + NB'(1);
              k_q   <= '0;
              acc_q <= bias_ext;
            end
          end else begin
            k_q   <= k_q + KB'(1);
            acc_q <= acc_sum;
          end
        end
        S_DONE: begin
          for (int n = 0; n < OUT_DIM; n++) begin
            out_flat_q[n*OUT_ACC_W +: OUT_ACC_W] <= score_q[n];
          end
          out_argmax_q <= best_idx_q;
          out_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hidden_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_flat     = out_flat_q;
  assign out_argmax   = out_argmax_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_mlp_output_layer.sv
// Scoreboard bench for mlp_output_layer: directed vectors push hand-computed
// scores, argmax and arrival cycle; a negedge monitor pops and compares.
module tb_mlp_output_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hidden_in_flat;
  logic        hidden_valid;
  logic        hidden_ready;
  logic        w_we;
  logic [2:0]  w_addr;
  logic [7:0]  w_data;
  logic        busy;
  logic [47:0] out_flat;
  logic [0:0]  out_argmax;
  logic        out_valid;

  typedef struct {
    int s0;
    int s1;
    int am;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mlp_output_layer dut (
    .clk            (clk),
    .rst            (rst),
    .hidden_in_flat (hidden_in_flat),
    .hidden_valid   (hidden_valid),
    .hidden_ready   (hidden_ready),
    .w_we           (w_we),
    .w_addr         (w_addr),
    .w_data         (w_data),
    .busy           (busy),
    .out_flat       (out_flat),
    .out_argmax     (out_argmax),
    .out_valid      (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("score0",  int'($signed(out_flat[23:0])),  mon_e.s0);
        check("score1",  int'($signed(out_flat[47:24])), mon_e.s1);
        check("argmax",  int'(out_argmax),               mon_e.am);
        check("latency", cyc,                            mon_e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // All driver tasks are entered right after a negedge and return at a negedge.
  task automatic wr(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = 3'(addr);
    w_data = 8'(data);
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic load(input int w00, w01, b0, w10, w11, b1);
    wr(0, w00); wr(1, w01); wr(2, b0);
    wr(3, w10); wr(4, w11); wr(5, b1);
  endtask

  task automatic send(input int h0, input int h1, input bit push,
                      input int s0, input int s1, input int am);
    exp_t e;
    hidden_in_flat = {16'(h1), 16'(h0)};
    hidden_valid   = 1'b1;
    if (push) begin
      e.s0 = s0; e.s1 = s1; e.am = am; e.cyc = cyc + 7;
      sb.push_back(e);
    end
    @(negedge clk);
    hidden_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; hidden_in_flat = '0; hidden_valid = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_hidden_ready", int'(hidden_ready), 1);
    check("rst_busy",         int'(busy),         0);
    check("rst_out_valid",    int'(out_valid),    0);
    check("rst_out_flat",     int'(out_flat != '0), 0);
    check("rst_argmax",       int'(out_argmax),   0);

    // Basic compute: q=[10,3] -> [19,-7].
    load(1, 2, 3, -1, 1, 0);
    send(160, 48, 1'b1, 19, -7, 0);
    drain();

    // Back-to-back: next vector the cycle after out_valid, q=[2,1] -> [7,-1].
    send(160, 48, 1'b1, 19, -7, 0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    @(negedge clk);
    check("b2b_hidden_ready", int'(hidden_ready), 1);
    send(32, 16, 1'b1, 7, -1, 0);
    drain();

    // Busy protection: hidden_valid and a weight write during MAC are dropped.
    send(160, 48, 1'b1, 19, -7, 0);
    @(negedge clk);
    check("mac_busy", int'(busy), 1);
    hidden_valid   = 1'b1;
    hidden_in_flat = {16'd500, 16'd500};
    w_we = 1'b1; w_addr = 3'd0; w_data = 8'h7F;
    @(negedge clk);
    hidden_valid = 1'b0; w_we = 1'b0;
    drain();
    // Out-of-range addresses are ignored; W0[0] must still be 1.
    wr(6, 8'h55);
    wr(7, 8'h55);
    send(160, 48, 1'b1, 19, -7, 0);
    drain();

    // Requantization edges: q=[0,127].
    load(1, 1, 0, 0, -1, 0);
    send(-500, 16'h7FFF, 1'b1, 127, -127, 0);
    drain();

    // Ties keep the lower index; negative bias.
    load(0, 0, 5, 0, 0, 5);
    send(160, 48, 1'b1, 5, 5, 0);
    drain();
    wr(2, -128);
    wr(5, 127);
    send(160, 48, 1'b1, -128, 127, 1);
    drain();

    // Reset mid-MAC aborts the run and clears everything.
    load(1, 2, 3, -1, 1, 0);
    send(160, 48, 1'b0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_score0",       int'($signed(out_flat[23:0])),  0);
    check("mid_rst_score1",       int'($signed(out_flat[47:24])), 0);
    check("mid_rst_argmax",       int'(out_argmax),   0);
    check("mid_rst_busy",         int'(busy),         0);
    check("mid_rst_hidden_ready", int'(hidden_ready), 1);
    repeat (10) @(negedge clk);
    send(160, 48, 1'b1, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlp_output_layer.md
Name: mlp_output_layer

Overview:
- Downstream stage of the hidden layer. Consumes `hidden_out_flat` and its completion pulse.
- Per input vector it does three things: requantizes each hidden accumulator (ReLU, arithmetic shift, saturate to `DATA_W`); runs a sequential single-MAC dot product against a locally stored weight/bias file for each output neuron; reports raw scores plus the argmax class.
- Weights are loaded through a simple write port, driven by the Avalon-MM wrapper.

Parameters:
- HIDDEN_SIZE, 2, number of hidden-layer values consumed.
- ACC_W, 16, width of each signed hidden accumulator input.
- DATA_W, 8, width of requantized activations and of signed weights/biases.
- OUT_DIM, 2, number of output neurons.
- OUT_ACC_W, 24, signed width of each output score.
- SHIFT, 4, right-shift applied during requantization.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- hidden_in_flat  in  ACC_W*HIDDEN_SIZE  signed hidden values; element i at [i*ACC_W +: ACC_W].
- hidden_valid  in  1  one-cycle pulse; hidden_in_flat is valid in that cycle.
- hidden_ready  out  1  high when a hidden_valid pulse will be accepted.
- w_we  in  1  weight write enable.
- w_addr  in  $clog2(OUT_DIM*(HIDDEN_SIZE+1))  weight index = n*(HIDDEN_SIZE+1)+k; k==HIDDEN_SIZE selects the bias of neuron n.
- w_data  in  DATA_W  signed weight/bias.
- busy  out  1  high in any non-IDLE state.
- out_flat  out  OUT_ACC_W*OUT_DIM  signed scores; neuron n at [n*OUT_ACC_W +: OUT_ACC_W].
- out_argmax  out  max(1,$clog2(OUT_DIM))  index of the largest score.
- out_valid  out  1  one-cycle pulse; out_flat and out_argmax are updated and stable from this cycle.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE; hidden_ready = 1; busy = 0; out_valid = 0.
  - out_flat = 0; out_argmax = 0.
  - All weights and biases = 0.
  - Internal capture registers, activations, accumulator and counters = 0.
- Reset mid-operation aborts the computation: no out_valid is produced, and all of the above values are restored.
- State machine (IDLE, QUANT, MAC, DONE):
  - IDLE: hidden_ready = 1. When hidden_valid = 1, capture hidden_in_flat, go to QUANT.
  - QUANT (1 cycle): for each i, q[i] = 0 if h[i] < 0; otherwise h[i] >>> SHIFT, saturated to 2^(DATA_W-1)-1. q is stored as signed DATA_W and is always non-negative. Then n = 0, k = 0, acc = sign-extended bias[0], go to MAC.
  - MAC (one product per cycle): acc += q[k]*W[n][k], using a signed 2*DATA_W product sign-extended to OUT_ACC_W. Arithmetic is two's-complement wrap; the defaults cannot overflow (|max| = 2*127*128+128 < 2^23).
  - MAC, when k == HIDDEN_SIZE-1:
    - Write the final sum to a staging score register for n.
    - Update the running best. n == 0 always sets best; a later n replaces best only if its score > best (strictly greater, so ties keep the lower index).
    - If n == OUT_DIM-1, go to DONE. Otherwise n++, k = 0, acc = bias[n+1].
  - DONE (1 cycle): copy staging scores to out_flat and best index to out_argmax; out_valid = 1; go to IDLE.
- Latency: 2 + OUT_DIM*HIDDEN_SIZE cycles from the hidden_valid sample edge to the out_valid cycle (6 with defaults). Throughput is one vector per 3 + OUT_DIM*HIDDEN_SIZE cycles.
- Boundary conditions:
  - hidden_valid while not IDLE (hidden_ready = 0): ignored, not queued.
  - hidden_valid in the cycle after out_valid: accepted.
  - w_we while busy = 1: the write is dropped, so weights are constant across a computation. Writes are accepted in IDLE, including the same cycle as hidden_valid; the write lands before QUANT reads the bias.
  - w_addr >= OUT_DIM*(HIDDEN_SIZE+1): write ignored.
  - out_flat and out_argmax hold their values between out_valid pulses.

Test Plan:
- Basic compute:
  - Load W0 = [1,2], b0 = 3; W1 = [-1,1], b1 = 0. Send h = [160, 48], giving q = [10,3].
  - Required: out_valid exactly 6 cycles after hidden_valid; out0 = 19, out1 = -7; out_argmax = 0.
- Requantization edges:
  - Send h = [-500, 0x7FFF], giving q = [0,127]. Weights W0 = [1,1], b0 = 0; W1 = [0,-1], b1 = 0.
  - Required: out0 = 127, out1 = -127, out_argmax = 0.
- Tie and negative bias:
  - All weights 0; b0 = 5, b1 = 5: scores [5,5], out_argmax = 0.
  - Then b0 = -128, b1 = 127: scores [-128,127], out_argmax = 1.
- Busy protection:
  - Repeat the basic-compute case, pulsing hidden_valid and w_we (addr 0, data 0x7F) during MAC.
  - Required: results unchanged [19,-7]; exactly one out_valid; W0[0] still 1 on the next run.
- Reset mid-MAC:
  - Assert rst 3 cycles after hidden_valid.
  - Required: no out_valid; out_flat = 0, out_argmax = 0, busy = 0, hidden_ready = 1 the cycle after rst deasserts.
  - A rerun without reloading weights yields [0,0].
- Back-to-back:
  - Send hidden_valid the cycle after out_valid with h = [32,16], giving q = [2,1], using the basic-compute weights.
  - Required: accepted; second out_valid 6 cycles later with [7,-1], out_argmax = 0.
